mod_seq_ctrl: RTL and testbench
===============================

Name: mod_seq_ctrl

Overview:
Sequencer for the modulator datapath (PRBS source followed by FIR shaping filter). It replaces free-running switch enables with a start/stop controlled sequence:
- generates the per-symbol valid strobe;
- primes the FIR with N_PRIME symbols before output is declared valid;
- drains the FIR with flush symbols on stop.
It sits between the board switches/buttons and the PRBS/FIR instances in the top level.

Parameters:
NB_COUNT, 3, phase counter width; symbol period = 2^NB_COUNT clocks
N_PRIME, 7, symbols needed to fill or flush the FIR (tap count minus one); must be >= 1
NB_SYM, 4, symbol counter width; must satisfy 2^NB_SYM > N_PRIME

Ports:
clock  in  1  system clock
i_reset  in  1  synchronous reset, active-low
i_start  in  1  level, sampled each clock; begins a sequence from IDLE
i_stop  in  1  level, sampled each clock; ends or aborts a sequence
i_hold  in  1  pause: freezes phase counter and symbol counter, suppresses o_valid
o_valid  out  1  one-clock symbol strobe to PRBS and FIR i_valid
o_prbs_enable  out  1  PRBS enable
o_fir_enable  out  1  FIR enable
o_flush  out  1  datapath must feed zero symbols into FIR
o_out_valid  out  1  qualifies FIR output (equals o_valid in RUN/DRAIN)
o_state  out  2  current state, for LEDs

Behaviour:
Reset (i_reset==0 at a clock edge):
- state=IDLE; phase counter=0; symbol counter=0.
- All outputs 0; o_state=2'd0.
- Reset overrides every other input, including mid-sequence.

States (encoding): IDLE=0, PRIME=1, RUN=2, DRAIN=3.

Phase counter:
- Held at 0 in IDLE.
- Otherwise increments by 1 each clock when i_hold==0; wraps from all-ones to 0.
- Frozen when i_hold==1.

o_valid:
- Combinational from registered state and counter: (state!=IDLE) && (count==all-ones) && !i_hold.
- Fires every 2^NB_COUNT clocks while un-held.

Symbol counter:
- Increments on o_valid in PRIME and DRAIN.
- Cleared on every state change.

IDLE:
- All enables 0.
- i_start=1 && i_stop=0 → PRIME next clock.
- If i_start and i_stop are both 1, stop wins and the block stays in IDLE.

PRIME:
- prbs_en=1, fir_en=1, flush=0, out_valid=0.
- On o_valid with sym_cnt==N_PRIME-1 → RUN.
- i_stop=1 → IDLE next clock (abort, no drain); stop takes priority over the prime-complete transition in the same cycle.

RUN:
- prbs_en=1, fir_en=1, flush=0, out_valid=o_valid.
- i_stop=1 → DRAIN next clock, regardless of phase.
- i_start is ignored.

DRAIN:
- prbs_en=0, fir_en=1, flush=1, out_valid=o_valid.
- On o_valid with sym_cnt==N_PRIME-1 → IDLE.
- i_start and i_stop are ignored; drain always completes unless reset.

Timing and hold:
- The phase counter is not reset on PRIME→RUN or RUN→DRAIN, so symbol spacing stays exactly 2^NB_COUNT un-held clocks across transitions.
- Latency with defaults: i_start sampled at edge k → PRIME from k.
  - First o_valid at cycle k+7.
  - Last prime valid at k+55; RUN from k+56.
  - First o_out_valid at k+63.
- i_hold in any state: the state is retained and i_stop is still honoured.

Decomposition:
- Shared package mod_pkg holds:
  - state encoding constants ST_IDLE/ST_PRIME/ST_RUN/ST_DRAIN (2 bits);
  - defaults NB_COUNT_DEF=3 and N_PRIME_DEF=7, reused by the top level and the FIR tap count.
- One natural sub-module: mod_symbol_timer.
  - Contains the phase counter and o_valid generation.
  - Inputs: clock, i_reset, run, hold. Output: valid.
- The FSM and symbol counter stay in mod_seq_ctrl.

Test Plan:
- Reset then idle: i_reset=0 for 3 clocks, release, no start → all outputs 0, o_state=0, no o_valid for 100 clocks.
- Full sequence, defaults: start pulse at k →
  - 7 o_valid in PRIME at k+7, k+15, …, k+55 with o_out_valid=0;
  - o_state=2 from k+56; o_out_valid at k+63, k+71.
- Stop in RUN at arbitrary phase (count=3) →
  - DRAIN next clock, flush=1, prbs_en=0;
  - valid spacing stays 8;
  - exactly 7 drain valids, then IDLE with all outputs 0.
- Abort in PRIME after 3 valids, i_stop=1 → IDLE next clock; no o_out_valid ever asserted; counters 0.
- Hold: i_hold=1 for 20 clocks mid-RUN →
  - no o_valid during hold;
  - next o_valid occurs 8-minus-elapsed-phase clocks after release;
  - i_start/i_stop simultaneous in IDLE → stays IDLE.
- Reset mid-DRAIN: i_reset=0 for 1 clock → IDLE and all outputs 0 on the next clock; a new start gives the same timing as the full-sequence scenario.

Source files
------------

// File: rtl/mod_pkg.sv
// Shared definitions for the modulator datapath: sequencer state encoding
// and the default symbol-timing / FIR-priming parameters.
package mod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

    // Symbol period is 2**NB_COUNT_DEF clocks; the FIR has N_PRIME_DEF+1 taps.
    localparam int NB_COUNT_DEF = 3;
    localparam int N_PRIME_DEF  = 7;

endpackage

// File: rtl/mod_symbol_timer.sv
// Free-running symbol phase counter; emits a one-clock strobe at the last
// phase of each symbol period while running and not held.
module mod_symbol_timer
    import mod_pkg::*;
#(
    parameter int NB_COUNT = NB_COUNT_DEF
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_hold,
    output logic o_valid
);

    logic [NB_COUNT-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!i_run) begin
            count_d = '0;
        end else if (!i_hold) begin
            count_d = count_q + NB_COUNT'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_valid = i_run && (count_q == '1) && !i_hold;

endmodule

// File: rtl/mod_seq_ctrl.sv
// Start/stop sequencer for the PRBS + FIR modulator: primes the FIR, runs,
// then drains it with zero symbols before returning to idle.
module mod_seq_ctrl
    import mod_pkg::*;
#(
    parameter int NB_COUNT = NB_COUNT_DEF,
    parameter int N_PRIME  = N_PRIME_DEF,
    parameter int NB_SYM   = 4
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_hold,
    output logic       o_valid,
    output logic       o_prbs_enable,
    output logic       o_fir_enable,
    output logic       o_flush,
    output logic       o_out_valid,
    output logic [1:0] o_state
);

    localparam logic [NB_SYM-1:0] LAST_SYM = NB_SYM'(N_PRIME - 1);

    seq_state_e        state_q, state_d;
    logic [NB_SYM-1:0] sym_q, sym_d;
    logic              sym_valid;
    logic              last_sym;

    mod_symbol_timer #(
        .NB_COUNT (NB_COUNT)
    ) u_timer (
        .clock   (clock),
        .i_reset (i_reset),
        .i_run   (state_q != ST_IDLE),
        .i_hold  (i_hold),
        .o_valid (sym_valid)
    );

    assign last_sym = sym_valid && (sym_q == LAST_SYM);

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        sym_d         = sym_q;
        o_prbs_enable = 1'b0;
        o_fir_enable  = 1'b0;
        o_flush       = 1'b0;
        o_out_valid   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                o_prbs_enable = 1'b1;
                o_fir_enable  = 1'b1;
                if (i_stop)        state_d = ST_IDLE;
                else if (last_sym) state_d = ST_RUN;
            end
            ST_RUN: begin
                o_prbs_enable = 1'b1;
                o_fir_enable  = 1'b1;
                o_out_valid   = sym_valid;
                if (i_stop) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_fir_enable = 1'b1;
                o_flush      = 1'b1;
                o_out_valid  = sym_valid;
                if (last_sym) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Symbols are only counted while priming or draining; any state
        // change restarts the count.
        if (state_d != state_q) begin
            sym_d = '0;
        end else if (sym_valid && (state_q == ST_PRIME || state_q == ST_DRAIN)) begin
            sym_d = sym_q + NB_SYM'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            sym_q   <= '0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
        end
    end

    assign o_valid = sym_valid;
    assign o_state = state_q;

endmodule

// File: tb/tb_mod_seq_ctrl.sv
// Directed bench for mod_seq_ctrl: a checkpoint table for the full sequence
// plus hand-written abort, hold and reset-mid-drain sequences.
module tb_mod_seq_ctrl;
    import mod_pkg::*;

    logic       clock;
    logic       i_reset;
    logic       i_start;
    logic       i_stop;
    logic       i_hold;
    logic       o_valid;
    logic       o_prbs_enable;
    logic       o_fir_enable;
    logic       o_flush;
    logic       o_out_valid;
    logic [1:0] o_state;

    int total = 0;
    int bad   = 0;
    int valid_cnt;
    int ov_cnt;

    // Observed/expected vector layout: {state[1:0], valid, prbs, fir, flush, out_valid}
    typedef struct {
        int         offset;
        logic       start;
        logic       stop;
        logic       hold;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[$];

    mod_seq_ctrl dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_hold        (i_hold),
        .o_valid       (o_valid),
        .o_prbs_enable (o_prbs_enable),
        .o_fir_enable  (o_fir_enable),
        .o_flush       (o_flush),
        .o_out_valid   (o_out_valid),
        .o_state       (o_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] ev(logic [1:0] s, logic v, logic p, logic f, logic fl, logic ov);
        return {s, v, p, f, fl, ov};
    endfunction

    function automatic logic [6:0] obs();
        return {o_state, o_valid, o_prbs_enable, o_fir_enable, o_flush, o_out_valid};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (o_valid)     valid_cnt++;
        if (o_out_valid) ov_cnt++;
    endtask

    // Start from IDLE and verify the default priming latency.
    task automatic run_prime_check(input string tag);
        int first_v;
        int nv;
        first_v = -1;
        nv      = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check({tag, "_prime_entry"}, obs(), ev(ST_PRIME, 0, 1, 1, 0, 0));
        for (int n = 1; n <= 56; n++) begin
            tick();
            if (o_valid) begin
                nv++;
                if (first_v < 0) first_v = n;
            end
            if (n == 55) check({tag, "_last_prime_valid"}, obs(), ev(ST_PRIME, 1, 1, 1, 0, 0));
        end
        check({tag, "_first_valid_at"}, first_v, 7);
        check({tag, "_prime_valids"}, nv, 7);
        check({tag, "_run_entry"}, obs(), ev(ST_RUN, 0, 1, 1, 0, 0));
    endtask

    initial begin
        int cur;
        int idle_bad;
        int delay;

        i_reset = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_hold  = 1'b0;
        valid_cnt = 0;
        ov_cnt    = 0;

        // Full sequence with a stop in RUN at phase 3 (cycle 75).
        tbl.push_back('{0,   0, 0, 0, ev(ST_PRIME, 0, 1, 1, 0, 0), "prime_start"});
        tbl.push_back('{6,   0, 0, 0, ev(ST_PRIME, 0, 1, 1, 0, 0), "prime_pre_valid"});
        tbl.push_back('{7,   0, 0, 0, ev(ST_PRIME, 1, 1, 1, 0, 0), "prime_valid1"});
        tbl.push_back('{8,   0, 0, 0, ev(ST_PRIME, 0, 1, 1, 0, 0), "prime_after_valid1"});
        tbl.push_back('{55,  0, 0, 0, ev(ST_PRIME, 1, 1, 1, 0, 0), "prime_valid7"});
        tbl.push_back('{56,  0, 0, 0, ev(ST_RUN,   0, 1, 1, 0, 0), "run_entry"});
        tbl.push_back('{63,  0, 0, 0, ev(ST_RUN,   1, 1, 1, 0, 1), "run_out_valid1"});
        tbl.push_back('{71,  0, 0, 0, ev(ST_RUN,   1, 1, 1, 0, 1), "run_out_valid2"});
        tbl.push_back('{75,  0, 1, 0, ev(ST_RUN,   0, 1, 1, 0, 0), "run_before_stop"});
        tbl.push_back('{76,  0, 0, 0, ev(ST_DRAIN, 0, 0, 1, 1, 0), "drain_entry"});
        tbl.push_back('{79,  0, 0, 0, ev(ST_DRAIN, 1, 0, 1, 1, 1), "drain_valid1"});
        tbl.push_back('{127, 0, 0, 0, ev(ST_DRAIN, 1, 0, 1, 1, 1), "drain_valid7"});
        tbl.push_back('{128, 0, 0, 0, ev(ST_IDLE,  0, 0, 0, 0, 0), "drain_done_idle"});

        // Reset for 3 clocks, then 100 idle clocks with nothing asserted.
        repeat (3) tick();
        check("reset_outputs", obs(), ev(ST_IDLE, 0, 0, 0, 0, 0));
        i_reset  = 1'b1;
        idle_bad = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (obs() != 7'd0) idle_bad++;
        end
        check("idle_100_quiet", idle_bad, 0);

        // Table-driven full sequence.
        valid_cnt = 0;
        ov_cnt    = 0;
        i_start   = 1'b1;
        tick();
        cur = 0;
        foreach (tbl[i]) begin
            while (cur < tbl[i].offset) begin
                tick();
                cur++;
            end
            check(tbl[i].name, obs(), tbl[i].exp);
            i_start = tbl[i].start;
            i_stop  = tbl[i].stop;
            i_hold  = tbl[i].hold;
        end
        check("full_seq_valid_count", valid_cnt, 16);
        check("full_seq_out_valid_count", ov_cnt, 9);

        // Abort in PRIME after three symbol strobes.
        repeat (5) tick();
        valid_cnt = 0;
        ov_cnt    = 0;
        i_start   = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (24) tick();
        check("abort_prime_valids", valid_cnt, 3);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("abort_to_idle", obs(), ev(ST_IDLE, 0, 0, 0, 0, 0));
        repeat (10) tick();
        check("abort_no_out_valid", ov_cnt, 0);

        // Simultaneous start and stop in IDLE: stop wins.
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick();
        tick();
        check("start_stop_stays_idle", obs(), ev(ST_IDLE, 0, 0, 0, 0, 0));
        i_start = 1'b0;
        i_stop  = 1'b0;
        tick();

        // Counters were cleared by the abort: same latency as a fresh start.
        run_prime_check("after_abort");

        // Hold for 20 clocks mid-RUN at phase 2 (three clocks after a strobe).
        repeat (10) tick();
        valid_cnt = 0;
        i_hold    = 1'b1;
        repeat (20) tick();
        check("hold_no_valid", valid_cnt, 0);
        check("hold_keeps_run", obs(), ev(ST_RUN, 0, 1, 1, 0, 0));
        i_hold = 1'b0;
        delay  = -1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (o_valid && delay < 0) begin
                delay = n;
                check("hold_release_strobe", obs(), ev(ST_RUN, 1, 1, 1, 0, 1));
            end
        end
        check("hold_release_delay", delay, 5);

        // Stop is honoured while held.
        i_hold = 1'b1;
        i_stop = 1'b1;
        tick();
        check("stop_during_hold", obs(), ev(ST_DRAIN, 0, 0, 1, 1, 0));
        i_hold = 1'b0;
        i_stop = 1'b0;

        // Reset for one clock in the middle of DRAIN.
        repeat (10) tick();
        i_reset = 1'b0;
        tick();
        check("reset_mid_drain", obs(), ev(ST_IDLE, 0, 0, 0, 0, 0));
        i_reset = 1'b1;
        tick();
        check("idle_after_reset", obs(), ev(ST_IDLE, 0, 0, 0, 0, 0));
        run_prime_check("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
